uart_rx_fifo: RTL
=================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning entry count (power of two, 2..256).
REQ-002 SHALL have parameter AW, default $clog2(DEPTH), meaning pointer width.
REQ-003 SHALL have port clk, input, 1 bit, meaning system clock; all state updates on its rising edge.
REQ-004 SHALL have port resetn, input, 1 bit, meaning reset, asynchronous, active-low.
REQ-005 SHALL have port recv_valid, input, 1 bit, meaning receiver stop-bit strobe; high for multiple consecutive cycles per byte.
REQ-006 SHALL have port recv_data, input, 8 bits, meaning received byte; stable from the second recv_valid cycle until the next byte.
REQ-007 SHALL have port recv_break, input, 1 bit, meaning receiver break indication; meaningful only while recv_valid is high.
REQ-008 SHALL have port clear, input, 1 bit, meaning synchronous flush plus overflow clear.
REQ-009 SHALL have port rx_valid, output, 1 bit, meaning head entry available.
REQ-010 SHALL have port rx_ready, input, 1 bit, meaning consumer accepts the head entry.
REQ-011 SHALL have port rx_data, output, 8 bits, meaning head entry byte.
REQ-012 SHALL have port rx_break, output, 1 bit, meaning head entry was a break.
REQ-013 SHALL have port count, output, AW+1 bits, meaning number of stored entries.
REQ-014 SHALL have ports full, empty and overflow, each output, 1 bit; overflow is sticky.

Function
REQ-015 Registered copy recv_valid_q SHALL detect the falling edge: commit = recv_valid_q && !recv_valid.
REQ-016 On commit, {break_seen, recv_data} SHALL be written at the write pointer; exactly one write per recv_valid pulse, regardless of pulse length.
REQ-017 break_seen SHALL be set on any cycle with recv_valid && recv_break, and cleared on the cycle after commit.
REQ-018 Pop SHALL occur when rx_valid && rx_ready; read pointer advances one entry.
REQ-019 rx_valid SHALL equal !empty; rx_data/rx_break SHALL be combinational reads of the head entry (zero-cycle latency).
REQ-020 A committed byte SHALL appear on rx_valid the cycle after commit.
REQ-021 Pointers SHALL be AW+1 bits and wrap modulo 2*DEPTH. empty = pointers equal. full = low AW bits equal and MSBs differ. count = wr_ptr - rd_ptr.
REQ-022 Commit while full without a same-cycle pop SHALL drop the byte, leave storage unchanged and set overflow.
REQ-023 Commit while full with a same-cycle pop SHALL accept the byte; count stays DEPTH; no overflow.
REQ-024 Commit while empty SHALL write; rx_valid is high next cycle; no same-cycle bypass.
REQ-025 Simultaneous commit and pop at any other fill level SHALL leave count unchanged.
REQ-026 clear SHALL zero both pointers, overflow and break_seen next cycle; a same-cycle commit or pop SHALL be ignored.
REQ-027 When clear is high, recv_valid_q SHALL still update, so a pulse spanning clear produces no write.

Reset
REQ-028 On resetn low: pointers = 0, recv_valid_q = 0, break_seen = 0, overflow = 0, therefore rx_valid = 0, empty = 1, full = 0, count = 0.
REQ-029 Storage contents SHALL not be reset; rx_data/rx_break are don't-care while empty.
REQ-030 Reset asserted mid-pulse SHALL discard the in-progress byte; recv_valid still high at release SHALL NOT cause a commit.

Configuration
REQ-031 Macro UART_RX_FIFO_BREAK_EN defined: entries SHALL be 9 bits and rx_break SHALL reflect the stored flag.
REQ-032 Macro UART_RX_FIFO_BREAK_EN undefined: entries SHALL be 8 bits, break_seen SHALL be removed, rx_break SHALL be tied 0 and recv_break SHALL be ignored.

Structure
REQ-033 Package uart_pkg SHALL hold UART_DATA_W = 8 and the entry-width constants for both configurations.
REQ-034 Storage SHALL be the sub-module uart_fifo_mem: 1 write port, asynchronous read port, DEPTH x width, no reset.

Verification
REQ-035 Bench SHALL cover: recv_valid high 10 cycles with recv_data 0xA5 -> exactly one entry; rx_data = 0xA5, rx_break = 0, count = 1.
REQ-036 Bench SHALL cover: recv_data 0x00 with recv_break high (BREAK_EN defined) -> rx_break = 1; undefined -> rx_break = 0.
REQ-037 Bench SHALL cover: DEPTH = 16, 17 bytes 0x00..0x10 with rx_ready = 0 -> full = 1, overflow = 1, then reads return 0x00..0x0F.
REQ-038 Bench SHALL cover: full FIFO, commit and pop in the same cycle -> count stays 16, overflow = 0, last entry read is the new byte.
REQ-039 Bench SHALL cover: 40 bytes with rx_ready toggling every cycle -> pointer wrap-around, in-order data, no loss.
REQ-040 Bench SHALL cover: clear with 5 entries and overflow set -> empty = 1, count = 0, overflow = 0 next cycle; resetn pulsed mid-pulse -> no entry written.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART widths and FIFO entry widths for both break-flag configurations
package uart_pkg;
    localparam int UART_DATA_W      = 8;
    localparam int UART_ENTRY_W     = UART_DATA_W;
    localparam int UART_ENTRY_W_BRK = UART_DATA_W + 1;
    typedef logic [UART_DATA_W-1:0] uart_byte_t;
endpackage

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: consumer-side valid/ready handshake carrying the FIFO head byte and break flag
interface uart_rx_fifo_if;
    import uart_pkg::*;
    logic       rx_valid;
    logic       rx_ready;
    uart_byte_t rx_data;
    logic       rx_break;
    modport master (output rx_valid, rx_data, rx_break, input rx_ready);
    modport slave  (input rx_valid, rx_data, rx_break, output rx_ready);
endinterface

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: DEPTH x W storage, one synchronous write port, asynchronous read port, no reset
module uart_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int W     = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [DEPTH];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: one-entry-per-stop-strobe receive FIFO; define UART_RX_FIFO_BREAK_EN to store a break flag per byte
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           recv_valid,
    input  uart_byte_t     recv_data,
    input  logic           recv_break,
    input  logic           clear,
    uart_rx_fifo_if.master rx,
    output logic [AW:0]    count,
    output logic           full,
    output logic           empty,
    output logic           overflow
);
`ifdef UART_RX_FIFO_BREAK_EN
    localparam int W = UART_ENTRY_W_BRK;
`else
    localparam int W = UART_ENTRY_W;
`endif
    logic [AW:0]  wr_ptr, rd_ptr;
    logic         recv_valid_q, armed, commit, pop, we;
    logic [W-1:0] wdata, rdata;
    assign commit      = recv_valid_q && !recv_valid;
    assign empty       = wr_ptr == rd_ptr;
    assign full        = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign count       = wr_ptr - rd_ptr;
    assign pop         = !empty && rx.rx_ready && !clear;
    assign we          = commit && !clear && (!full || pop);
    assign rx.rx_valid = !empty;
    assign rx.rx_data  = rdata[UART_DATA_W-1:0];
    // armed stays low until recv_valid is seen low, so a pulse already in flight at reset release is never committed
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            armed        <= 1'b0;
            recv_valid_q <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            overflow     <= 1'b0;
        end else begin
            armed        <= armed || !recv_valid;
            recv_valid_q <= recv_valid && armed;
            wr_ptr       <= clear ? '0 : wr_ptr + {{AW{1'b0}}, we};
            rd_ptr       <= clear ? '0 : rd_ptr + {{AW{1'b0}}, pop};
            overflow     <= !clear && (overflow || (commit && full && !pop));
        end
`ifdef UART_RX_FIFO_BREAK_EN
    logic break_seen;
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) break_seen <= 1'b0;
        else         break_seen <= (clear || commit) ? 1'b0 : break_seen || (recv_valid && recv_break && armed);
    assign wdata       = {break_seen, recv_data};
    assign rx.rx_break = rdata[W-1];
`else
    logic unused_break;
    assign unused_break = recv_break;
    assign wdata        = recv_data;
    assign rx.rx_break  = 1'b0;
`endif
    uart_fifo_mem #(.DEPTH(DEPTH), .W(W), .AW(AW)) u_mem (
        .clk   (clk),
        .we    (we),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (wdata),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rdata)
    );
endmodule
